// File: rtl/conv_seq_pkg.sv
// Shared types and default widths for the conv layer-1 sequencer.
package conv_seq_pkg;

  localparam int IN_W_DEF   = 16;
  localparam int OUT_W_DEF  = 32;
  localparam int ADDR_W_DEF = 10;
  localparam int LEN_W_DEF  = 10;
  localparam int BIAS_W     = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_WAIT,
    ST_OUT,
    ST_ERROR
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_INVALID  = 2'b01,
    ERR_TIMEOUT  = 2'b10,
    ERR_ZERO_LEN = 2'b11
  } err_code_t;

endpackage

// File: rtl/conv_seq_watchdog.sv
// WAIT-state watchdog: cleared by load, counts while en, expire on the LIMIT-th enabled cycle.
// Expire is combinational from the count; no backpressure. LIMIT must be at least 2.
module conv_seq_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic h_clk,
  input  logic reset_n,
  input  logic load,
  input  logic en,
  output logic expire
);

  localparam int CW = $clog2(LIMIT);

  logic [CW-1:0] cnt_q;

  assign expire = en && (cnt_q == CW'(LIMIT - 1));

  always_ff @(posedge h_clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (en && !expire) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/conv_layer_seq.sv
// Streams cfg_len SRAM words to the conv accelerator, then hands its result over valid/ready.
// First acc_valid 2 cycles after start; result held until res_ready. CONV_SEQ_TIMEOUT_EN adds a WAIT watchdog.
module conv_layer_seq import conv_seq_pkg::*; #(
  parameter int IN_W   = IN_W_DEF,
  parameter int OUT_W  = OUT_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
`ifdef CONV_SEQ_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 1024
`endif
) (
  input  logic              h_clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [BIAS_W-1:0] cfg_bias,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [IN_W-1:0]   mem_rd_data,
  output logic [IN_W-1:0]   acc_input_port,
  output logic [BIAS_W-1:0] acc_bias,
  output logic              acc_valid,
  output logic              acc_reset,
  input  logic [OUT_W-1:0]  acc_output_port,
  input  logic              acc_finish,
  input  logic              acc_invalid,
  output logic [OUT_W-1:0]  res_data,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  state_t             state_q, state_d;
  err_code_t          code_q, code_d;
  logic               err_q, err_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   rd_cnt_q;
  logic [LEN_W-1:0]   ret_cnt_q;
  logic               rd_pend_q;
  logic [BIAS_W-1:0]  bias_q;
  logic [OUT_W-1:0]   res_q;
  logic               acc_reset_q;
  logic               start_ok;
  logic               last_ret;
  logic               timeout;

  assign start_ok = start && (state_q == ST_IDLE);
  assign last_ret = rd_pend_q && (ret_cnt_q == len_q - LEN_W'(1));

`ifdef CONV_SEQ_TIMEOUT_EN
  conv_seq_watchdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_wdog (
    .h_clk   (h_clk),
    .reset_n (reset_n),
    .load    (state_q != ST_WAIT),
    .en      (state_q == ST_WAIT),
    .expire  (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    err_d     = err_q;
    mem_rd_en = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          if (cfg_len == '0) begin
            state_d = ST_ERROR;
            code_d  = ERR_ZERO_LEN;
            err_d   = 1'b1;
          end else begin
            state_d = ST_CLEAR;
            code_d  = ERR_NONE;
            err_d   = 1'b0;
          end
        end
      end
      // The first read goes out alongside the accelerator clear to save a cycle.
      ST_CLEAR: begin
        mem_rd_en = 1'b1;
        state_d   = ST_STREAM;
      end
      ST_STREAM: begin
        if (acc_invalid) begin
          state_d = ST_ERROR;
          code_d  = ERR_INVALID;
          err_d   = 1'b1;
        end else begin
          mem_rd_en = (rd_cnt_q != len_q);
          if (last_ret) state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (acc_invalid) begin
          state_d = ST_ERROR;
          code_d  = ERR_INVALID;
          err_d   = 1'b1;
        end else if (acc_finish) begin
          state_d = ST_OUT;
        end else if (timeout) begin
          state_d = ST_ERROR;
          code_d  = ERR_TIMEOUT;
          err_d   = 1'b1;
        end
      end
      ST_OUT: begin
        if (res_ready) begin
          state_d = ST_IDLE;
          done    = 1'b1;
        end
      end
      ST_ERROR: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // acc_reset resets high; a zero-length job never touches the accelerator.
  always_ff @(posedge h_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      code_q      <= ERR_NONE;
      err_q       <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      rd_cnt_q    <= '0;
      ret_cnt_q   <= '0;
      rd_pend_q   <= 1'b0;
      bias_q      <= '0;
      res_q       <= '0;
      acc_reset_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      err_q       <= err_d;
      rd_pend_q   <= mem_rd_en;
      acc_reset_q <= (state_d == ST_CLEAR) ||
                     ((state_d == ST_ERROR) && (code_d != ERR_ZERO_LEN));
      if (start_ok) begin
        addr_q    <= cfg_base;
        len_q     <= cfg_len;
        bias_q    <= cfg_bias;
        rd_cnt_q  <= '0;
        ret_cnt_q <= '0;
      end else begin
        if (mem_rd_en) begin
          addr_q   <= addr_q + ADDR_W'(1);
          rd_cnt_q <= rd_cnt_q + LEN_W'(1);
        end
        if (rd_pend_q && (state_q == ST_STREAM)) begin
          ret_cnt_q <= ret_cnt_q + LEN_W'(1);
        end
      end
      if ((state_q == ST_WAIT) && acc_finish && !acc_invalid) begin
        res_q <= acc_output_port;
      end
    end
  end

  assign mem_rd_addr    = addr_q;
  assign acc_valid      = rd_pend_q;
  assign acc_input_port = rd_pend_q ? mem_rd_data : '0;
  assign acc_bias       = bias_q;
  assign acc_reset      = acc_reset_q;
  assign res_data       = res_q;
  assign res_valid      = (state_q == ST_OUT);
  assign busy           = (state_q != ST_IDLE);
  assign err            = err_q;
  assign err_code       = code_q;

endmodule

// File: tb/tb_conv_layer_seq.sv
// Directed bench for conv_layer_seq with an SRAM model and a hand-driven accelerator.
module tb_conv_layer_seq;

  logic        h_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [9:0]  cfg_base = '0;
  logic [9:0]  cfg_len = '0;
  logic [31:0] cfg_bias = '0;
  logic        mem_rd_en;
  logic [9:0]  mem_rd_addr;
  logic [15:0] mem_rd_data = '0;
  logic [15:0] acc_input_port;
  logic [31:0] acc_bias;
  logic        acc_valid;
  logic        acc_reset;
  logic [31:0] acc_output_port = '0;
  logic        acc_finish = 1'b0;
  logic        acc_invalid = 1'b0;
  logic [31:0] res_data;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  conv_layer_seq dut (
    .h_clk           (h_clk),
    .reset_n         (reset_n),
    .start           (start),
    .cfg_base        (cfg_base),
    .cfg_len         (cfg_len),
    .cfg_bias        (cfg_bias),
    .mem_rd_en       (mem_rd_en),
    .mem_rd_addr     (mem_rd_addr),
    .mem_rd_data     (mem_rd_data),
    .acc_input_port  (acc_input_port),
    .acc_bias        (acc_bias),
    .acc_valid       (acc_valid),
    .acc_reset       (acc_reset),
    .acc_output_port (acc_output_port),
    .acc_finish      (acc_finish),
    .acc_invalid     (acc_invalid),
    .res_data        (res_data),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .busy            (busy),
    .done            (done),
    .err             (err),
    .err_code        (err_code)
  );

  always #5 h_clk = ~h_clk;

  logic [15:0] sram [0:1023];
  always @(posedge h_clk) if (mem_rd_en) mem_rd_data <= sram[mem_rd_addr];

  logic [9:0]  addr_log[$];
  logic [15:0] word_log[$];
  int          rst_pulses = 0;

  always @(negedge h_clk) begin
    if (reset_n) begin
      if (mem_rd_en) addr_log.push_back(mem_rd_addr);
      if (acc_valid) word_log.push_back(acc_input_port);
      if (acc_reset) rst_pulses++;
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge h_clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    addr_log.delete();
    word_log.delete();
    rst_pulses = 0;
  endtask

  task automatic launch(input logic [9:0] b, input logic [9:0] l, input logic [31:0] bias);
    cfg_base = b;
    cfg_len  = l;
    cfg_bias = bias;
    start    = 1'b1;
    step(1);
    start    = 1'b0;
  endtask

  initial begin
    int waited;
    logic [9:0]  exp_addr[4];
    logic [15:0] exp_word[4];
    for (int i = 0; i < 1024; i++) sram[i] = 16'(i * 3 + 7);
    sram[10'h010] = 16'd1;
    sram[10'h011] = 16'd2;
    sram[10'h012] = 16'd3;
    sram[10'h013] = 16'd4;
    sram[10'h3FE] = 16'h000A;
    sram[10'h3FF] = 16'h000B;
    sram[10'h000] = 16'h000C;
    sram[10'h001] = 16'h000D;

    // Reset state
    #12;
    check("rst_acc_reset", acc_reset, 1);
    check("rst_busy", busy, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_acc_valid", acc_valid, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_err_code", err_code, 0);
    step(1);
    reset_n = 1'b1;
    step(1);

    // A stray finish in IDLE must be ignored
    acc_output_port = 32'h77;
    acc_finish = 1'b1;
    step(1);
    acc_finish = 1'b0;
    check("idle_finish_busy", busy, 0);
    check("idle_finish_res_valid", res_valid, 0);

    // Test 1: base 0x10, len 4, bias 5
    clear_logs();
    launch(10'h010, 10'd4, 32'd5);
    check("t1_clear_busy", busy, 1);
    check("t1_clear_acc_reset", acc_reset, 1);
    check("t1_clear_rd_en", mem_rd_en, 1);
    check("t1_clear_rd_addr", mem_rd_addr, 10'h010);
    check("t1_clear_acc_valid", acc_valid, 0);
    step(5);
    check("t1_nwords", word_log.size(), 4);
    check("t1_nreads", addr_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_word%0d", i), word_log[i], 16'(i + 1));
      check($sformatf("t1_addr%0d", i), addr_log[i], 10'(16 + i));
    end
    check("t1_wait_acc_valid", acc_valid, 0);
    check("t1_bias", acc_bias, 5);
    check("t1_rst_pulses", rst_pulses, 1);
    check("t1_wait_res_valid", res_valid, 0);
    acc_output_port = 32'h64;
    acc_finish = 1'b1;
    step(1);
    acc_finish = 1'b0;
    check("t1_res_valid", res_valid, 1);
    check("t1_res_data", res_data, 32'h64);
    check("t1_done_pre", done, 0);
    res_ready = 1'b1;
    #1;
    check("t1_done", done, 1);
    step(1);
    res_ready = 1'b0;
    check("t1_idle_busy", busy, 0);
    check("t1_idle_res_valid", res_valid, 0);
    check("t1_idle_done", done, 0);
    check("t1_err", err, 0);

    // Test 2: consumer stalls for 10 cycles
    launch(10'h010, 10'd4, 32'd5);
    step(5);
    acc_output_port = 32'hDEADBEEF;
    acc_finish = 1'b1;
    step(1);
    acc_finish = 1'b0;
    acc_output_port = 32'h0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("t2_res_valid_%0d", i), res_valid, 1);
      check($sformatf("t2_res_data_%0d", i), res_data, 32'hDEADBEEF);
      check($sformatf("t2_done_%0d", i), done, 0);
      step(1);
    end
    res_ready = 1'b1;
    #1;
    check("t2_done_accept", done, 1);
    step(1);
    res_ready = 1'b0;
    check("t2_idle_busy", busy, 0);

    // Test 3: acc_invalid on the second streamed word
    clear_logs();
    launch(10'h010, 10'd4, 32'd7);
    step(2);
    acc_invalid = 1'b1;
    #1;
    check("t3_word2_valid", acc_valid, 1);
    check("t3_word2", acc_input_port, 2);
    check("t3_rd_stopped", mem_rd_en, 0);
    step(1);
    acc_invalid = 1'b0;
    check("t3_err_acc_reset", acc_reset, 1);
    check("t3_err_acc_valid", acc_valid, 0);
    check("t3_err", err, 1);
    check("t3_err_code", err_code, 2'b01);
    check("t3_done", done, 1);
    step(1);
    check("t3_idle_busy", busy, 0);
    check("t3_idle_done", done, 0);
    check("t3_err_sticky", err, 1);
    check("t3_nreads", addr_log.size(), 2);
    check("t3_nwords", word_log.size(), 2);
    check("t3_rst_pulses", rst_pulses, 2);

    // Test 5: address wrap, start while busy ignored, err cleared by start
    clear_logs();
    launch(10'h3FE, 10'd4, 32'h1234);
    check("t5_err_cleared", err, 0);
    check("t5_code_cleared", err_code, 0);
    step(2);
    cfg_base = 10'h100;
    cfg_len  = 10'd7;
    cfg_bias = 32'd99;
    start    = 1'b1;
    step(1);
    start    = 1'b0;
    step(2);
    exp_addr = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    exp_word = '{16'h000A, 16'h000B, 16'h000C, 16'h000D};
    check("t5_nreads", addr_log.size(), 4);
    check("t5_nwords", word_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t5_addr%0d", i), addr_log[i], exp_addr[i]);
      check($sformatf("t5_word%0d", i), word_log[i], exp_word[i]);
    end
    check("t5_bias_held", acc_bias, 32'h1234);
    check("t5_wait_acc_valid", acc_valid, 0);
    acc_output_port = 32'h55;
    acc_finish = 1'b1;
    step(1);
    acc_finish = 1'b0;
    check("t5_res_data", res_data, 32'h55);
    res_ready = 1'b1;
    step(1);
    res_ready = 1'b0;
    check("t5_idle_busy", busy, 0);

    // Test 4: zero length
    clear_logs();
    launch(10'h020, 10'd0, 32'd9);
    check("t4_busy", busy, 1);
    check("t4_err", err, 1);
    check("t4_err_code", err_code, 2'b11);
    check("t4_done", done, 1);
    check("t4_acc_reset", acc_reset, 0);
    step(1);
    check("t4_idle_busy", busy, 0);
    check("t4_idle_done", done, 0);
    check("t4_nreads", addr_log.size(), 0);
    check("t4_nwords", word_log.size(), 0);

    // Test 6: reset mid-stream
    launch(10'h010, 10'd4, 32'd5);
    step(2);
    reset_n = 1'b0;
    #1;
    check("t6_rd_en", mem_rd_en, 0);
    check("t6_rd_addr", mem_rd_addr, 0);
    check("t6_acc_valid", acc_valid, 0);
    check("t6_acc_input", acc_input_port, 0);
    check("t6_acc_bias", acc_bias, 0);
    check("t6_acc_reset", acc_reset, 1);
    check("t6_busy", busy, 0);
    check("t6_res_data", res_data, 0);
    check("t6_err_code", err_code, 0);
    step(1);
    reset_n = 1'b1;
    step(1);

    // Watchdog behaviour with a single-word job and no finish
    launch(10'h010, 10'd1, 32'd5);
    step(2);
    check("wd_in_wait", busy, 1);
`ifdef CONV_SEQ_TIMEOUT_EN
    waited = 0;
    while (!err && waited < 1100) begin
      step(1);
      waited++;
    end
    check("wd_err", err, 1);
    check("wd_err_code", err_code, 2'b10);
    check("wd_cycles", waited, 1024);
    check("wd_done", done, 1);
    step(1);
`else
    waited = 1100;
    step(waited);
    check("wd_no_timeout_err", err, 0);
    check("wd_still_busy", busy, 1);
    check("wd_no_res_valid", res_valid, 0);
    acc_output_port = 32'h1;
    acc_finish = 1'b1;
    step(1);
    acc_finish = 1'b0;
    res_ready = 1'b1;
    step(1);
    res_ready = 1'b0;
`endif
    check("wd_final_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
